// File: rtl/cpu_clkgen.sv
// phi2 clock generator: programmable half-period, hold freeze, wait-state stretching.
// Optional CLKGEN_CYCLE_COUNTER_EN adds a phi2 rise counter output (cycle_count).
module cpu_clkgen #(
  parameter int                   DIV_WIDTH   = 8,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(3),
  parameter int                   WAIT_WIDTH  = 4,
  parameter int                   CNT_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div_in,
  input  logic                  div_wr,
  input  logic                  hold,
  input  logic [WAIT_WIDTH-1:0] wait_n,
  input  logic                  wait_req,
  output logic                  phi2,
  output logic                  phi2_rise,
  output logic                  phi2_fall,
  output logic [DIV_WIDTH-1:0]  div_active,
  output logic                  div_pending,
  output logic                  held
`ifdef CLKGEN_CYCLE_COUNTER_EN
  ,
  output logic [CNT_WIDTH-1:0]  cycle_count
`endif
);

  typedef enum logic [1:0] {S_LOW, S_HIGH, S_STRETCH, S_HOLD} state_t;

  state_t                state, state_nx;
  logic [DIV_WIDTH-1:0]  cnt, cnt_nx;
  logic [WAIT_WIDTH-1:0] scnt, scnt_nx;
  logic [WAIT_WIDTH-1:0] wait_lat, wait_lat_nx;
  logic                  wait_vld, wait_vld_nx;
  logic [DIV_WIDTH-1:0]  div_pend_val;
  logic                  go_rise, go_fall;
  logic                  at_end;
  logic                  wait_hit;
  logic [WAIT_WIDTH-1:0] wait_sel;

  // A counter narrower than one bit cannot hold any count.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end

  assign at_end   = (cnt == div_active);
  // A request arriving on the last base cycle still counts for this phase.
  assign wait_hit = wait_vld | wait_req;
  assign wait_sel = wait_vld ? wait_lat : wait_n;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    scnt_nx     = scnt;
    wait_lat_nx = wait_lat;
    wait_vld_nx = wait_vld;
    go_rise     = 1'b0;
    go_fall     = 1'b0;
    case (state)
      S_LOW: begin
        if (at_end) begin
          if (hold) state_nx = S_HOLD;
          else      go_rise  = 1'b1;
        end else begin
          cnt_nx = cnt + DIV_WIDTH'(1);
        end
      end
      S_HIGH: begin
        if (!wait_vld && wait_req) begin
          wait_vld_nx = 1'b1;
          wait_lat_nx = wait_n;
        end
        if (at_end) begin
          if (wait_hit && (wait_sel != '0)) begin
            state_nx = S_STRETCH;
            scnt_nx  = wait_sel;
          end else begin
            go_fall = 1'b1;
          end
        end else begin
          cnt_nx = cnt + DIV_WIDTH'(1);
        end
      end
      S_STRETCH: begin
        // Falling when the count reaches zero gives exactly wait_n extra clocks.
        scnt_nx = scnt - WAIT_WIDTH'(1);
        if (scnt == WAIT_WIDTH'(1)) go_fall = 1'b1;
      end
      S_HOLD: begin
        if (!hold) go_rise = 1'b1;
      end
      default: state_nx = S_LOW;
    endcase
    if (go_rise) begin
      state_nx = S_HIGH;
      cnt_nx   = '0;
    end
    if (go_fall) begin
      state_nx    = S_LOW;
      cnt_nx      = '0;
      wait_vld_nx = 1'b0;
      wait_lat_nx = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_LOW;
      cnt          <= '0;
      scnt         <= '0;
      wait_lat     <= '0;
      wait_vld     <= 1'b0;
      phi2         <= 1'b0;
      phi2_rise    <= 1'b0;
      phi2_fall    <= 1'b0;
      held         <= 1'b0;
      div_active   <= DEFAULT_DIV;
      div_pend_val <= DEFAULT_DIV;
      div_pending  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      scnt      <= scnt_nx;
      wait_lat  <= wait_lat_nx;
      wait_vld  <= wait_vld_nx;
      phi2_rise <= go_rise;
      phi2_fall <= go_fall;
      held      <= (state_nx == S_HOLD);
      if (go_rise)      phi2 <= 1'b1;
      else if (go_fall) phi2 <= 1'b0;
      // Pending divisor takes effect at the fall so it spans a whole low phase;
      // a write landing on that same edge waits for the following fall.
      if (go_fall && div_pending) div_active <= div_pend_val;
      if (div_wr) begin
        div_pend_val <= div_in;
        div_pending  <= 1'b1;
      end else if (go_fall) begin
        div_pending  <= 1'b0;
      end
    end
  end

`ifdef CLKGEN_CYCLE_COUNTER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        cycle_count <= '0;
    else if (go_rise) cycle_count <= cycle_count + CNT_WIDTH'(1);
  end
`endif

endmodule
